text_blitter: RTL and testbench
===============================

Name: text_blitter

Overview:
- Downstream consumer of the keyboard letter-conversion stage: takes the 5-bit letter array (codes 0-25 = A-Z, 26 = space) once conversion completes.
- Draws each letter as an 8x8 glyph into the passport frame buffer at a programmable origin.
- Walks letters, glyph rows and glyph columns with an FSM and counters. Fetches glyph rows from a synchronous font ROM and issues single-pixel writes under a ready/valid handshake.

Parameters:
TEXT_LEN_MAX, 20, number of letter slots in letter_array
IMG_W, 320, frame buffer width in pixels
IMG_H, 240, frame buffer height in pixels
ADDR_W, 17, frame buffer address width
PIX_W, 12, pixel data width

Ports:
clock_27mhz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
letter_array  in  TEXT_LEN_MAX*5  letter codes; slot i at bits [5i+4:5i]
letter_array_rdy  in  1  high when letter_array is valid; a 0->1 transition starts a blit
origin_x  in  9  x of top-left of first (leftmost) glyph
origin_y  in  8  y of top-left of glyph row 0
text_color  in  PIX_W  colour written for set glyph bits
font_addr  out  8  font ROM address = code*8 + glyph_row
font_data  in  8  ROM row data, valid 1 cycle after font_addr; bit 7 = leftmost column
fb_addr  out  ADDR_W  write address = y*IMG_W + x
fb_wdata  out  PIX_W  write data
fb_we  out  1  write request
fb_ready  in  1  frame buffer accepts write when fb_we && fb_ready
busy  out  1  high from blit start until done
done  out  1  one-cycle pulse when blit completes

Behaviour:
- Reset (async, reset_n=0):
  - FSM enters IDLE.
  - busy=0, done=0, fb_we=0, fb_addr=0, fb_wdata=0, font_addr=0.
  - Internal rdy-edge register is cleared to 1, so a letter_array_rdy held high out of reset does not start a blit.
- Start:
  - A registered edge detect on letter_array_rdy fires in IDLE only.
  - On the start cycle: latch letter_array, origin_x, origin_y, text_color; set busy=1 next cycle.
  - Edges seen while busy are ignored, with no queueing.
- Letter order:
  - Display position k (0 = leftmost) uses slot TEXT_LEN_MAX-1-k, because the first typed character occupies the top slot.
  - Glyph x of position k = origin_x + 8k.
- FSM states:
  - IDLE -> LOAD on start.
  - LOAD: 1 cycle. k=0, row=0.
  - CHECK: if code >= 26 (space or invalid), go to NEXT_LETTER; else go to FETCH.
  - FETCH: drive font_addr = code*8+row. 1 cycle.
  - WAIT: 1 cycle (ROM latency). Capture font_data into row shift register; col=0.
  - WRITE: per column:
    - If the bit is 0 or the pixel is clipped: no write, advance col in 1 cycle.
    - Otherwise assert fb_we with fb_addr/fb_wdata; hold all three stable until fb_ready. Advance col on the accepted cycle.
    - After col 7: if row<7, row++ and go to FETCH; else go to NEXT_LETTER.
  - NEXT_LETTER: 1 cycle. If k = TEXT_LEN_MAX-1, go to DONE; else k++, row=0, go to CHECK.
  - DONE: done=1 for 1 cycle, busy=0 next cycle, return to IDLE.
- Clipping: pixel (x,y) with x >= IMG_W or y >= IMG_H is never written. Compute sums at 10/9 bits so they do not wrap.
- Addresses:
  - fb_addr = y*IMG_W + x, computed in the cycle before fb_we rises.
  - Pipelining that multiply is allowed only if cycle counts below hold for fb_ready=1.
- Timing with fb_ready=1 throughout:
  - Non-space letter = 1 (CHECK) + 8*(1+1+8) + 1 (NEXT_LETTER) = 82 cycles.
  - Space = 2 cycles.
  - Write count is independent of glyph pattern, since writes complete in 1 cycle each.
- Background pixels (bit 0) are left untouched; the block never writes a background colour.
- fb_we never asserts outside WRITE. No two writes target the same address within one blit unless glyphs overlap via clipping-free geometry (by construction they do not).
- Reset mid-blit: fb_we drops immediately (async). Partially drawn text remains in the frame buffer.
- fb_ready stuck low: the block stalls in WRITE indefinitely, with busy=1. No timeout.

Test Plan:
- Reset with letter_array_rdy=1, hold 10 cycles -> busy=0, no fb_we, no done.
- Top slot code 0 (A), all other slots 26; rdy 0->1; origin (0,0); fb_ready=1 -> fb_we pulses equal popcount of A glyph rows; addresses within x 0-7, y 0-7; done after 1+1+82+19*2+1 cycles; font_addr sequence 0..7.
- Same letters, origin (316,236) -> only pixels with x<=319 and y<=239 written; no address >= 76800.
- fb_ready toggled 1-of-3 cycles during a write -> fb_addr/fb_wdata stable while fb_we=1 && fb_ready=0; total accepted writes unchanged.
- Second rdy edge while busy -> ignored, single done pulse; edge after done -> new blit starts.
- reset_n low mid-WRITE -> fb_we=0 asynchronously; after release, busy=0, no further writes until a new rdy edge.

Source files
------------

// File: rtl/text_blitter.sv
// Draws the letter array as 8x8 glyphs into the frame buffer at a programmable origin.
// Glyph rows come from a synchronous font ROM; each set bit becomes one ready/valid pixel write.
module text_blitter #(
  parameter int TEXT_LEN_MAX = 20,
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int ADDR_W       = 17,
  parameter int PIX_W        = 12
) (
  input  logic                      clock_27mhz,
  input  logic                      reset_n,
  input  logic [TEXT_LEN_MAX*5-1:0] letter_array,
  input  logic                      letter_array_rdy,
  input  logic [8:0]                origin_x,
  input  logic [7:0]                origin_y,
  input  logic [PIX_W-1:0]          text_color,
  output logic [7:0]                font_addr,
  input  logic [7:0]                font_data,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [PIX_W-1:0]          fb_wdata,
  output logic                      fb_we,
  input  logic                      fb_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int K_W = (TEXT_LEN_MAX > 1) ? $clog2(TEXT_LEN_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_FETCH, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_e;

  state_e                             state_q, state_d;
  logic                               rdy_q, rdy_d;
  logic [TEXT_LEN_MAX-1:0][4:0]       letters_q, letters_d;
  logic [8:0]                         ox_q, ox_d;
  logic [7:0]                         oy_q, oy_d;
  logic [PIX_W-1:0]                   color_q, color_d;
  logic [K_W-1:0]                     k_q, k_d;
  logic [2:0]                         row_q, row_d;
  logic [2:0]                         col_q, col_d;
  logic [6:0]                         bits_q, bits_d;
  logic [7:0]                         font_addr_q, font_addr_d;
  logic [ADDR_W-1:0]                  fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]                   fb_wdata_q, fb_wdata_d;
  logic                               fb_we_q, fb_we_d;

  logic                               start;
  logic [K_W-1:0]                     slot;
  logic [4:0]                         code;
  logic [2:0]                         issue_col;
  logic                               issue_bit;
  logic [9:0]                         glyph_x;
  logic [9:0]                         pix_x;
  logic [8:0]                         pix_y;
  logic                               pix_in;
  logic [ADDR_W-1:0]                  pix_addr;

  // Pixel for the column about to be issued: col 0 straight from the ROM in WAIT,
  // otherwise the next column out of the row shift register.
  always_comb begin
    issue_col = (state_q == S_WAIT) ? 3'd0 : col_q + 3'd1;
    issue_bit = (state_q == S_WAIT) ? font_data[7] : bits_q[6];
    glyph_x   = 10'(ox_q) + 10'({k_q, 3'b000});
    pix_x     = glyph_x + 10'(issue_col);
    pix_y     = 9'(oy_q) + 9'(row_q);
    pix_in    = (pix_x < 10'(IMG_W)) && (pix_y < 9'(IMG_H));
    pix_addr  = ADDR_W'(32'(pix_y) * 32'(IMG_W) + 32'(pix_x));
  end

  always_comb begin
    state_d     = state_q;
    rdy_d       = letter_array_rdy;
    letters_d   = letters_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    color_d     = color_q;
    k_d         = k_q;
    row_d       = row_q;
    col_d       = col_q;
    bits_d      = bits_q;
    font_addr_d = font_addr_q;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    fb_we_d     = fb_we_q;
    start       = (state_q == S_IDLE) && letter_array_rdy && !rdy_q;
    // Leftmost position reads the top slot (first typed character).
    slot        = K_W'(TEXT_LEN_MAX - 1) - k_q;
    code        = letters_q[slot];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          letters_d = letter_array;
          ox_d      = origin_x;
          oy_d      = origin_y;
          color_d   = text_color;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        k_d     = '0;
        row_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (code >= 5'd26) begin
          state_d = S_NEXT;
        end else begin
          font_addr_d = {code, row_q};
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        bits_d  = font_data[6:0];
        col_d   = '0;
        fb_we_d = issue_bit && pix_in;
        if (issue_bit && pix_in) begin
          fb_addr_d  = pix_addr;
          fb_wdata_d = color_q;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!fb_we_q || fb_ready) begin
          if (col_q == 3'd7) begin
            fb_we_d = 1'b0;
            if (row_q != 3'd7) begin
              row_d       = row_q + 3'd1;
              font_addr_d = {code, row_q + 3'd1};
              state_d     = S_FETCH;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            col_d   = col_q + 3'd1;
            bits_d  = {bits_q[5:0], 1'b0};
            fb_we_d = issue_bit && pix_in;
            if (issue_bit && pix_in) begin
              fb_addr_d  = pix_addr;
              fb_wdata_d = color_q;
            end
          end
        end
      end
      S_NEXT: begin
        if (k_q == K_W'(TEXT_LEN_MAX - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          row_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rdy_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b1;
      letters_q   <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      color_q     <= '0;
      k_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      bits_q      <= '0;
      font_addr_q <= '0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      fb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      letters_q   <= letters_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      color_q     <= color_d;
      k_q         <= k_d;
      row_q       <= row_d;
      col_q       <= col_d;
      bits_q      <= bits_d;
      font_addr_q <= font_addr_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      fb_we_q     <= fb_we_d;
    end
  end

  assign font_addr = font_addr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign fb_we     = fb_we_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_text_blitter.sv
// Randomised bench for text_blitter against a glyph-walk reference model and a font ROM model.
module tb_text_blitter;
  localparam int TL = 20, IW = 320, IH = 240, AW = 17, PW = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TL*5-1:0]   letter_array = '0;
  logic              letter_array_rdy = 1'b1;
  logic [8:0]        origin_x = '0;
  logic [7:0]        origin_y = '0;
  logic [PW-1:0]     text_color = '0;
  logic [7:0]        font_addr;
  logic [7:0]        font_data = '0;
  logic [AW-1:0]     fb_addr;
  logic [PW-1:0]     fb_wdata;
  logic              fb_we;
  logic              fb_ready = 1'b1;
  logic              busy, done;

  text_blitter #(.TEXT_LEN_MAX(TL), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clock_27mhz(clk), .reset_n(rst_n), .letter_array(letter_array),
    .letter_array_rdy(letter_array_rdy), .origin_x(origin_x), .origin_y(origin_y),
    .text_color(text_color), .font_addr(font_addr), .font_data(font_data),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  always @(posedge clk) font_data <= rom[font_addr];

  int tests = 0, fails = 0;
  int cyc = 0, ready_mode = 0;
  int wr_addr[$], wr_data[$], fa_seq[$];
  int exp_addr[$], exp_fa[$];
  int done_cnt, we_seen, stall_bad, stall_seen;
  logic [7:0] last_fa, init_fa;
  logic hold_v = 1'b0;
  logic [AW-1:0] hold_a;
  logic [PW-1:0] hold_d;

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); fa_seq.delete();
    done_cnt = 0; we_seen = 0; stall_bad = 0; stall_seen = 0;
    last_fa = font_addr; init_fa = font_addr; hold_v = 1'b0;
  endtask

  // One clock: update fb_ready after the edge, sample everything on the falling edge.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    case (ready_mode)
      0:       fb_ready = 1'b1;
      1:       fb_ready = (cyc % 3 == 0);
      default: fb_ready = 1'b0;
    endcase
    @(negedge clk);
    if (done) done_cnt++;
    if (fb_we) we_seen++;
    if (font_addr != last_fa) begin fa_seq.push_back(int'(font_addr)); last_fa = font_addr; end
    if (hold_v && (!fb_we || fb_addr !== hold_a || fb_wdata !== hold_d)) stall_bad++;
    hold_v = fb_we && !fb_ready;
    if (hold_v) stall_seen++;
    hold_a = fb_addr; hold_d = fb_wdata;
    if (fb_we && fb_ready) begin wr_addr.push_back(int'(fb_addr)); wr_data.push_back(int'(fb_wdata)); end
  endtask

  // Reference: walk positions left to right, rows top to bottom, columns left to right.
  task automatic model(input logic [TL*5-1:0] la, input int ox, input int oy, output int ncyc);
    int code, x, y, prev;
    exp_addr.delete(); exp_fa.delete();
    ncyc = 3;
    prev = int'(init_fa);
    for (int k = 0; k < TL; k++) begin
      code = int'(la[(TL-1-k)*5 +: 5]);
      if (code >= 26) begin ncyc += 2; continue; end
      ncyc += 82;
      for (int r = 0; r < 8; r++) begin
        if (code*8 + r != prev) exp_fa.push_back(code*8 + r);
        prev = code*8 + r;
        for (int c = 0; c < 8; c++) begin
          x = ox + 8*k + c; y = oy + r;
          if (rom[code*8 + r][7-c] && x < IW && y < IH) exp_addr.push_back(y*IW + x);
        end
      end
    end
  endtask

  task automatic run_blit(input logic [TL*5-1:0] la, input int ox, input int oy,
                          input logic [PW-1:0] col, output int n, output bit tmo);
    letter_array = la; origin_x = ox[8:0]; origin_y = oy[7:0]; text_color = col;
    letter_array_rdy = 1'b0;
    tick();
    clear_logs();
    letter_array_rdy = 1'b1;
    n = 0; tmo = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      tick(); n++;
      if (done_cnt > 0) begin tmo = 1'b0; break; end
    end
    repeat (3) tick();
  endtask

  function automatic logic [TL*5-1:0] only_a();
    logic [TL*5-1:0] la;
    for (int k = 0; k < TL; k++) la[k*5 +: 5] = 5'd26;
    la[(TL-1)*5 +: 5] = 5'd0;
    return la;
  endfunction

  task automatic test_reset();
    letter_array_rdy = 1'b1; rst_n = 1'b0;
    #1;
    tests++; if ({busy, done, fb_we} !== 3'b000) begin fails++; $display("FAIL reset_outs: busy/done/we=%b want 000", {busy, done, fb_we}); end
    tests++; if (fb_addr !== '0 || fb_wdata !== '0 || font_addr !== '0) begin fails++; $display("FAIL reset_regs: addr=%0d wdata=%0d fa=%0d want 0", fb_addr, fb_wdata, font_addr); end
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (10) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_rdy_busy: busy=%b want 0", busy); end
    tests++; if (we_seen != 0 || done_cnt != 0) begin fails++; $display("FAIL reset_rdy_quiet: we=%0d done=%0d want 0 0", we_seen, done_cnt); end
  endtask

  task automatic test_letter_a();
    int n, ne, bad, pc, xy_bad; bit tmo;
    pc = 0;
    for (int r = 0; r < 8; r++) pc += $countones(rom[r]);
    run_blit(only_a(), 0, 0, 12'hABC, n, tmo);
    model(only_a(), 0, 0, ne);
    tests++; if (tmo) begin fails++; $display("FAIL a_timeout: no done within budget"); end
    tests++; if (wr_addr.size() != pc) begin fails++; $display("FAIL a_popcount: writes=%0d want %0d", wr_addr.size(), pc); end
    xy_bad = 0; bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] % IW > 7 || wr_addr[i] / IW > 7) xy_bad++;
    foreach (wr_data[i]) if (wr_data[i] != 'hABC) bad++;
    tests++; if (xy_bad != 0) begin fails++; $display("FAIL a_xy_range: %0d writes outside 8x8", xy_bad); end
    tests++; if (bad != 0) begin fails++; $display("FAIL a_wdata: %0d writes with wrong colour", bad); end
    bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[i]) if (wr_addr[i] != exp_addr[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL a_addr_seq: got %0d writes want %0d, %0d diffs", wr_addr.size(), exp_addr.size(), bad); end
    tests++; if (n != 1+1+82+19*2+1 - 1 || n != ne - 1) begin fails++; $display("FAIL a_cycles: done after %0d cycles want %0d", n, ne - 1); end
    bad = (fa_seq.size() != exp_fa.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_fa[i]) if (fa_seq[i] != exp_fa[i]) bad++;
    tests++; if (bad != 0 || font_addr !== 8'd7) begin fails++; $display("FAIL a_font_addr: %0d changes (want %0d), last=%0d want 7", fa_seq.size(), exp_fa.size(), font_addr); end
    tests++; if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL a_done: pulses=%0d busy=%b want 1 0", done_cnt, busy); end
  endtask

  task automatic test_clip();
    int n, ne, bad, want; bit tmo;
    want = 0;
    for (int r = 0; r < 4; r++) want += $countones(rom[r][7:4]);
    run_blit(only_a(), 316, 236, 12'h5A5, n, tmo);
    model(only_a(), 316, 236, ne);
    tests++; if (tmo) begin fails++; $display("FAIL clip_timeout: no done within budget"); end
    tests++; if (wr_addr.size() != want) begin fails++; $display("FAIL clip_count: writes=%0d want %0d", wr_addr.size(), want); end
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] >= IW*IH || wr_addr[i] % IW < 316 || wr_addr[i] / IW < 236) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL clip_range: %0d writes outside visible corner", bad); end
    bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[i]) if (wr_addr[i] != exp_addr[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL clip_addr_seq: got %0d writes want %0d, %0d diffs", wr_addr.size(), exp_addr.size(), bad); end
  endtask

  task automatic test_random();
    int n, ne, bad, ox, oy; bit tmo;
    logic [TL*5-1:0] la;
    logic [PW-1:0] col;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < TL; k++) la[k*5 +: 5] = 5'($urandom_range(0, 31));
      ox = (it == 0) ? $urandom_range(0, 150) : $urandom_range(0, 511);
      oy = $urandom_range(0, 255);
      col = PW'($urandom);
      run_blit(la, ox, oy, col, n, tmo);
      model(la, ox, oy, ne);
      tests++; if (tmo || n != ne - 1) begin fails++; $display("FAIL rand%0d_cycles: done after %0d want %0d (tmo=%0b)", it, n, ne - 1, tmo); end
      bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
      if (bad == 0) foreach (exp_addr[i]) if (wr_addr[i] != exp_addr[i] || wr_data[i] != int'(col)) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL rand%0d_writes: got %0d want %0d, %0d diffs", it, wr_addr.size(), exp_addr.size(), bad); end
    end
  endtask

  task automatic test_ready_toggle();
    int n, ne, bad; bit tmo;
    logic [TL*5-1:0] la;
    for (int k = 0; k < TL; k++) la[k*5 +: 5] = 5'($urandom_range(0, 27));
    la[(TL-1)*5 +: 5] = 5'd0;
    ready_mode = 1;
    run_blit(la, 40, 100, 12'h0F0, n, tmo);
    ready_mode = 0;
    model(la, 40, 100, ne);
    tests++; if (tmo) begin fails++; $display("FAIL rdy_timeout: no done within budget"); end
    tests++; if (stall_bad != 0 || stall_seen == 0) begin fails++; $display("FAIL rdy_stable: %0d unstable stalls, %0d stalls seen (want 0, >0)", stall_bad, stall_seen); end
    bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[i]) if (wr_addr[i] != exp_addr[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL rdy_writes: got %0d want %0d, %0d diffs", wr_addr.size(), exp_addr.size(), bad); end
  endtask

  task automatic test_back_to_back();
    int n, ne, bad; bit tmo;
    letter_array = only_a(); origin_x = 9'd8; origin_y = 8'd8; text_color = 12'h123;
    letter_array_rdy = 1'b0;
    tick();
    clear_logs();
    letter_array_rdy = 1'b1;
    repeat (20) tick();
    letter_array_rdy = 1'b0; tick();
    letter_array_rdy = 1'b1;
    for (int i = 0; i < 400; i++) tick();
    model(only_a(), 8, 8, ne);
    tests++; if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_single_done: pulses=%0d busy=%b want 1 0", done_cnt, busy); end
    bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_addr[i]) if (wr_addr[i] != exp_addr[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_writes: got %0d want %0d, %0d diffs", wr_addr.size(), exp_addr.size(), bad); end
    run_blit(only_a(), 8, 8, 12'h123, n, tmo);
    tests++; if (tmo || done_cnt != 1 || wr_addr.size() != exp_addr.size()) begin fails++; $display("FAIL b2b_restart: tmo=%0b done=%0d writes=%0d want 0 1 %0d", tmo, done_cnt, wr_addr.size(), exp_addr.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    letter_array = only_a(); origin_x = '0; origin_y = '0;
    letter_array_rdy = 1'b0;
    tick();
    letter_array_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin tick(); seen = fb_we; end
    tests++; if (!seen) begin fails++; $display("FAIL mid_no_write: fb_we never rose"); end
    rst_n = 1'b0;
    #1;
    tests++; if (fb_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_async: we=%b busy=%b want 0 0", fb_we, busy); end
    repeat (3) tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    tests++; if (busy !== 1'b0 || we_seen != 0 || done_cnt != 0) begin fails++; $display("FAIL mid_after: busy=%b we=%0d done=%0d want 0 0 0", busy, we_seen, done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h18; rom[1] = 8'h24; rom[2] = 8'h42; rom[3] = 8'h42;
    rom[4] = 8'h7E; rom[5] = 8'h42; rom[6] = 8'hC3; rom[7] = 8'h81;
    test_reset();
    test_letter_a();
    test_clip();
    test_random();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
